// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Purpose : bundles the upstream (arithmetic unit) and downstream (consumer)
//           handshake/data signals of alu_result_stage.
// Signals : In_Valid/In_Ready, Op, B_in, raw unit results (Add_out,
//           CarryOut_Add, Sub_out, CarryOut_Sub, Mult_out, Div_out,
//           Remainder_out), Out_Valid/Out_Ready, Result, Flags, Level.
// Modports: master = producer/consumer side (testbench or neighbours),
//           slave  = the result stage itself.
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
  parameter int DEPTH = 2
);
  logic                     In_Valid;
  logic                     In_Ready;
  logic [2:0]               Op;
  logic [3:0]               B_in;
  logic [3:0]               Add_out;
  logic                     CarryOut_Add;
  logic [3:0]               Sub_out;
  logic                     CarryOut_Sub;
  logic [7:0]               Mult_out;
  logic [3:0]               Div_out;
  logic [3:0]               Remainder_out;
  logic                     Out_Valid;
  logic                     Out_Ready;
  logic [7:0]               Result;
  logic [3:0]               Flags;
  logic [$clog2(DEPTH):0]   Level;

  modport master (
    output In_Valid, Op, B_in, Add_out, CarryOut_Add, Sub_out, CarryOut_Sub,
           Mult_out, Div_out, Remainder_out, Out_Ready,
    input  In_Ready, Out_Valid, Result, Flags, Level
  );

  modport slave (
    input  In_Valid, Op, B_in, Add_out, CarryOut_Add, Sub_out, CarryOut_Sub,
           Mult_out, Div_out, Remainder_out, Out_Ready,
    output In_Ready, Out_Valid, Result, Flags, Level
  );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Purpose : registered output stage behind the 4-bit arithmetic unit. Selects
//           and formats one 8-bit result per transaction, computes flags
//           {Illegal, DivZero, Carry, Zero}, buffers entries in a DEPTH-entry
//           FIFO with valid/ready handshakes, and keeps a saturating count of
//           accepted erroneous operations.
// Ports   : Clk, Rst_n (async, active low)
//           bus       - alu_result_stage_if.slave (handshakes, data, Level)
//           Err_Clear - synchronous clear of Err_Count
//           Err_Count - saturating error counter
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  alu_result_stage_if.slave  bus,
  input  logic               Err_Clear,
  output logic [CNT_W-1:0]   Err_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MUL    = 3'd2,
    OP_DIV    = 3'd3,
    OP_REM    = 3'd4,
    OP_DIVREM = 3'd5
  } op_e;

  logic [7:0]        mem_q [DEPTH];
  logic [3:0]        flg_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q,  count_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              full, empty, push, pop;
  logic [7:0]        fmt_result;
  logic              fmt_illegal, fmt_divzero, fmt_carry;
  logic [3:0]        fmt_flags;

  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);
  // No pass-through: a pop in the same cycle does not free a slot when full.
  assign push  = bus.In_Valid & ~full;
  assign pop   = ~empty & bus.Out_Ready;

  // Result/flag formatting from the arithmetic unit's parallel outputs.
  always_comb begin
    fmt_result  = 8'h00;
    fmt_illegal = 1'b0;
    fmt_divzero = 1'b0;
    fmt_carry   = 1'b0;
    case (bus.Op)
      OP_ADD: begin
        fmt_result = {4'h0, bus.Add_out};
        fmt_carry  = bus.CarryOut_Add;
      end
      OP_SUB: begin
        fmt_result = {4'h0, bus.Sub_out};
        fmt_carry  = bus.CarryOut_Sub;
      end
      OP_MUL: begin
        fmt_result = bus.Mult_out;
        fmt_carry  = |bus.Mult_out[7:4];
      end
      OP_DIV, OP_REM, OP_DIVREM: begin
        if (bus.B_in == 4'h0) begin
          fmt_divzero = 1'b1;
        end else if (bus.Op == OP_DIV) begin
          fmt_result = {4'h0, bus.Div_out};
        end else if (bus.Op == OP_REM) begin
          fmt_result = {4'h0, bus.Remainder_out};
        end else begin
          fmt_result = {bus.Remainder_out, bus.Div_out};
        end
      end
      default: fmt_illegal = 1'b1;
    endcase
    fmt_flags = {fmt_illegal, fmt_divzero, fmt_carry, (fmt_result == 8'h00)};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear has priority over an increment in the same cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (Err_Clear) begin
      err_cnt_d = '0;
    end else if (push && (fmt_illegal || fmt_divzero) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is reset too so Result/Flags read zero out of reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
        flg_q[i] <= 4'h0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= fmt_result;
      flg_q[wr_ptr_q] <= fmt_flags;
    end
  end

  assign bus.In_Ready  = ~full;
  assign bus.Out_Valid = ~empty;
  assign bus.Result    = mem_q[rd_ptr_q];
  assign bus.Flags     = flg_q[rd_ptr_q];
  assign bus.Level     = count_q;
  assign Err_Count     = err_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Purpose : self-checking bench for alu_result_stage. A driver issues
//           transactions and pushes the expected {Result, Flags} into a
//           scoreboard queue when the DUT accepts; a monitor pops and
//           compares whenever the DUT presents an entry that is consumed.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] b;
    logic [3:0] add;
    logic       cadd;
    logic [3:0] sub;
    logic       csub;
    logic [7:0] mul;
    logic [3:0] div;
    logic [3:0] rem;
  } txn_t;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;

  logic             Clk;
  logic             Rst_n;
  logic             Err_Clear;
  logic [CNT_W-1:0] Err_Count;

  alu_result_stage_if #(.DEPTH(DEPTH)) bus ();

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .bus       (bus.slave),
    .Err_Clear (Err_Clear),
    .Err_Count (Err_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: formatting rules applied to one transaction.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    logic ill, dz, c;
    e.r = 8'h00; ill = 0; dz = 0; c = 0;
    case (t.op)
      3'd0: begin e.r = {4'h0, t.add}; c = t.cadd; end
      3'd1: begin e.r = {4'h0, t.sub}; c = t.csub; end
      3'd2: begin e.r = t.mul; c = (t.mul >= 8'h10); end
      3'd3, 3'd4, 3'd5: begin
        if (t.b == 0) dz = 1;
        else if (t.op == 3'd3) e.r = {4'h0, t.div};
        else if (t.op == 3'd4) e.r = {4'h0, t.rem};
        else e.r = {t.rem, t.div};
      end
      default: ill = 1;
    endcase
    e.f = {ill, dz, c, (e.r == 8'h00)};
    return e;
  endfunction

  // Random transaction built from real operands, as the arithmetic unit would.
  function automatic txn_t rand_txn();
    txn_t t;
    int a, b, s, d;
    a = $urandom_range(0, 15);
    b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
    s = a + b;
    d = a - b;
    t.op   = 3'($urandom_range(0, 7));
    t.b    = 4'(b);
    t.add  = 4'(s);
    t.cadd = (s > 15);
    t.sub  = 4'(d);
    t.csub = (a < b);
    t.mul  = 8'(a * b);
    t.div  = (b != 0) ? 4'(a / b) : 4'($urandom);
    t.rem  = (b != 0) ? 4'(a % b) : 4'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input logic [2:0] op, input logic [3:0] b, input logic [3:0] add,
                              input logic cadd, input logic [7:0] mul, input logic [3:0] div,
                              input logic [3:0] rem);
    txn_t t;
    t.op = op; t.b = b; t.add = add; t.cadd = cadd; t.sub = 4'h5; t.csub = 1'b1;
    t.mul = mul; t.div = div; t.rem = rem;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    bus.Op = t.op; bus.B_in = t.b; bus.Add_out = t.add; bus.CarryOut_Add = t.cadd;
    bus.Sub_out = t.sub; bus.CarryOut_Sub = t.csub; bus.Mult_out = t.mul;
    bus.Div_out = t.div; bus.Remainder_out = t.rem;
  endtask

  // Called in the cycle before the edge at which the DUT accepts t.
  task automatic accept_model(input txn_t t);
    exp_t e;
    e = model(t);
    sb.push_back(e);
    if (Err_Clear) mcnt = 0;
    else if ((e.f[3] || e.f[2]) && mcnt < CMAX) mcnt++;
  endtask

  task automatic send(input txn_t t);
    bit acc;
    acc = 0;
    drive(t);
    bus.In_Valid = 1'b1;
    for (int cyc = 0; cyc < 50 && !acc; cyc++) begin
      @(negedge Clk);
      if (bus.In_Ready) begin
        accept_model(t);
        acc = 1;
      end
      @(posedge Clk); #1;
    end
    bus.In_Valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // Monitor: compares the head entry on every cycle it is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus.Out_Valid && bus.Out_Ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {24'h0, bus.Result}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("result", {24'h0, bus.Result}, {24'h0, e.r});
          chk("flags",  {28'h0, bus.Flags},  {28'h0, e.f});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clk); #2;
      if (rand_rdy) bus.Out_Ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    txn_t t;
    int   acc;

    Rst_n = 1'b0; Err_Clear = 1'b0;
    bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
    drive(mk(3'd0, 4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 4'h0));
    #12;
    chk("rst_out_valid", {31'h0, bus.Out_Valid}, 32'd0);
    chk("rst_in_ready",  {31'h0, bus.In_Ready},  32'd1);
    chk("rst_result",    {24'h0, bus.Result},    32'd0);
    chk("rst_flags",     {28'h0, bus.Flags},     32'd0);
    chk("rst_level",     32'(bus.Level),         32'd0);
    chk("rst_err_count", 32'(Err_Count),         32'd0);
    #10 Rst_n = 1'b1;
    idle(2);

    // ADD 0xF with carry
    send(mk(3'd0, 4'h3, 4'hF, 1'b1, 8'h00, 4'h0, 4'h0));
    chk("add_out_valid", {31'h0, bus.Out_Valid}, 32'd1);
    chk("add_result",    {24'h0, bus.Result},    32'h0F);
    chk("add_flags",     {28'h0, bus.Flags},     32'b0010);
    chk("add_level",     32'(bus.Level),         32'd1);
    idle(2);

    // MUL then DIVREM, back to back
    send(mk(3'd2, 4'h7, 4'h0, 1'b0, 8'hE1, 4'h0, 4'h0));
    send(mk(3'd5, 4'h4, 4'h0, 1'b0, 8'h00, 4'h3, 4'h2));
    idle(3);
    chk("sb_drained_1", sb.size(), 32'd0);

    // Divide by zero, then illegal op
    send(mk(3'd3, 4'h0, 4'h1, 1'b1, 8'h44, 4'h9, 4'h6));
    send(mk(3'd7, 4'h2, 4'h1, 1'b1, 8'h44, 4'h9, 4'h6));
    idle(2);
    chk("err_count_2", 32'(Err_Count), 32'd2);

    // Fill with consumer stalled, In_Valid held
    bus.Out_Ready = 1'b0;
    t = rand_txn();
    drive(t);
    bus.In_Valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bit took;
      took = 0;
      @(negedge Clk);
      if (bus.In_Ready) begin accept_model(t); acc++; took = 1; end
      @(posedge Clk); #1;
      if (took) begin t = rand_txn(); drive(t); end
    end
    chk("full_accepts",  acc,                    DEPTH);
    chk("full_in_ready", {31'h0, bus.In_Ready},  32'd0);
    chk("full_level",    32'(bus.Level),         DEPTH);
    bus.Out_Ready = 1'b1;
    @(negedge Clk);
    chk("full_pop_no_push", {31'h0, bus.In_Ready}, 32'd0);
    @(posedge Clk); #1;
    bus.Out_Ready = 1'b0;
    chk("after_pop_level", 32'(bus.Level), DEPTH - 1);
    @(negedge Clk);
    chk("late_push_ready", {31'h0, bus.In_Ready}, 32'd1);
    if (bus.In_Ready) accept_model(t);
    @(posedge Clk); #1;
    bus.In_Valid = 1'b0;
    chk("late_push_level", 32'(bus.Level), DEPTH);
    bus.Out_Ready = 1'b1;
    idle(DEPTH + 2);
    chk("full_drain_level", 32'(bus.Level), 32'd0);

    // Randomized traffic with random consumer stalls
    rand_rdy = 1;
    for (int n = 0; n < 300; n++) send(rand_txn());
    rand_rdy = 0;
    @(posedge Clk); #1;
    bus.Out_Ready = 1'b1;
    for (int w = 0; w < 100 && sb.size() != 0; w++) idle(1);
    idle(1);
    chk("rand_drained",   sb.size(),       32'd0);
    chk("rand_err_count", 32'(Err_Count), mcnt);

    // Saturation of the error counter
    while (mcnt < CMAX) send(mk(3'd6, 4'h1, 4'h2, 1'b0, 8'h10, 4'h1, 4'h1));
    idle(1);
    chk("err_at_max", 32'(Err_Count), CMAX);
    send(mk(3'd4, 4'h0, 4'h2, 1'b0, 8'h10, 4'h1, 4'h1));
    idle(1);
    chk("err_saturated", 32'(Err_Count), CMAX);
    Err_Clear = 1'b1;
    send(mk(3'd7, 4'h1, 4'h2, 1'b0, 8'h10, 4'h1, 4'h1));
    Err_Clear = 1'b0;
    chk("err_clear_wins", 32'(Err_Count), 32'd0);
    idle(3);

    // Mid-operation reset with two entries buffered
    bus.Out_Ready = 1'b0;
    send(mk(3'd3, 4'h0, 4'h2, 1'b0, 8'h10, 4'h1, 4'h1));
    send(mk(3'd6, 4'h1, 4'h2, 1'b0, 8'h10, 4'h1, 4'h1));
    chk("pre_rst_level", 32'(bus.Level),   32'd2);
    chk("pre_rst_err",   32'(Err_Count),  mcnt);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, bus.Out_Valid}, 32'd0);
    chk("mid_rst_level",     32'(bus.Level),         32'd0);
    chk("mid_rst_err",       32'(Err_Count),         32'd0);
    chk("mid_rst_in_ready",  {31'h0, bus.In_Ready},  32'd1);
    sb.delete();
    mcnt = 0;
    #3 Rst_n = 1'b1;
    bus.Out_Ready = 1'b1;
    idle(2);

    // Post-reset sanity
    send(mk(3'd1, 4'h9, 4'h0, 1'b0, 8'h00, 4'h0, 4'h0));
    idle(3);
    chk("final_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
